store_buffer: RTL

- Sits directly upstream of the word-addressed data memory; sole master of that memory's read/write/address/data pins.
- Accepts stores from the execute stage into a small FIFO, drains them to memory one per free cycle, and services loads with store-to-load forwarding.
- Decouples execute-stage stores from the memory's single access per cycle.

---
 rtl/sb_pkg.sv | 16 +
 rtl/sb_fwd_match.sv | 44 ++++
 rtl/store_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: default widths, the buffered
// entry layout and the pointer width for the default depth.
package sb_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match of a load against the buffered stores and
// the store arriving in the same cycle (which is younger than all entries).
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic                         st_valid,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest from head so later matches override earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
    if (st_valid && (st_addr == ld_addr)) begin
      hit  = 1'b1;
      data = st_data;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of the word-addressed data memory: queues stores,
// drains them one per free memory cycle and forwards to loads.
// Optional macro STORE_BUFFER_COALESCE_EN merges a store into the youngest
// entry when the addresses match.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_st_valid,
  input  logic [ADDR_W-1:0] in_st_addr,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              out_st_ready,
  input  logic              in_ld_valid,
  input  logic [ADDR_W-1:0] in_ld_addr,
  output logic              out_ld_ready,
  output logic              out_ld_done,
  output logic [DATA_W-1:0] out_ld_data,
  input  logic              in_flush,
  output logic              out_empty,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  input  logic [DATA_W-1:0] in_mem_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]               count;
  logic [PTR_W-1:0]             head, tail, ytail;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic                         full, ld_acc, st_acc, coal, alloc, drain;
  logic                         fwd_hit;
  logic [DATA_W-1:0]            fwd_data;
  logic                         vld_p0, hit_p0;
  logic [DATA_W-1:0]            fwd_data_p0;

  assign full  = (count == FULL_CNT);
  assign ytail = tail - PTR_W'(1);

  sb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .head      (head),
    .st_valid  (in_st_valid && !in_flush && !rst),
    .st_addr   (in_st_addr),
    .st_data   (in_st_data),
    .ld_addr   (in_ld_addr),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

  // A full buffer or a flush gives the port to the drain; otherwise a load
  // that misses owns it. Draining is held off during reset so discarded
  // stores never reach memory.
  assign out_ld_ready  = !(full || in_flush);
  assign ld_acc        = in_ld_valid && out_ld_ready;
  assign out_mem_read  = ld_acc && !fwd_hit;
  assign drain         = (count != '0) && !out_mem_read && !rst;
  assign out_mem_write = drain;

`ifdef STORE_BUFFER_COALESCE_EN
  assign coal = in_st_valid && !in_flush && (count != '0) && ent_valid[ytail] &&
                (ent_addr[ytail] == in_st_addr) && !(drain && (ytail == head));
`else
  assign coal = 1'b0;
`endif

  assign out_st_ready = ((!full && !in_flush) || coal) && !rst;
  assign st_acc       = in_st_valid && out_st_ready;
  assign alloc        = st_acc && !coal;
  assign out_empty    = (count == '0);
  assign out_ld_done  = vld_p0;
  assign out_ld_data  = vld_p0 ? (hit_p0 ? fwd_data_p0 : in_mem_data) : '0;

  // Memory pin mux; pins idle at zero when neither access is issued.
  always_comb begin
    out_mem_addr = '0;
    out_mem_data = '0;
    if (drain) begin
      out_mem_addr = ent_addr[head];
      out_mem_data = ent_data[head];
    end else if (out_mem_read) begin
      out_mem_addr = in_ld_addr;
    end
  end

  // Control state: pointers, occupancy, entry valid bits, load result valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      vld_p0    <= 1'b0;
    end else begin
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      case ({alloc, drain})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      vld_p0 <= ld_acc;
    end
  end

  // Datapath: entry payloads and the forwarded value for next cycle.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= in_st_addr;
      ent_data[tail] <= in_st_data;
    end
    if (coal) ent_data[ytail] <= in_st_data;
    // stage p0: load result selection registered
    hit_p0      <= fwd_hit;
    fwd_data_p0 <= fwd_data;
  end

endmodule
